// File: rtl/rf_wb_pkg.sv
// ============================================================================
// Module   : rf_wb_pkg
// Purpose  : Shared widths and the writeback request type for the RF write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rf_wb_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int REG_IDX_W    = 5;
  localparam int NUM_REGS     = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0]    rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_req_t;

endpackage

`default_nettype wire

// File: rtl/rf_writeback_arbiter_if.sv
// ============================================================================
// Module   : rf_writeback_arbiter_if
// Purpose  : Pipe/long-latency result inputs and register-file write outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface rf_writeback_arbiter_if #(
  parameter int XLEN = rf_wb_pkg::XLEN_DEFAULT
);

  logic                            pipe_wb_valid;
  logic [rf_wb_pkg::REG_IDX_W-1:0] pipe_wb_rd;
  logic [XLEN-1:0]                 pipe_wb_data;
  logic                            ll_valid;
  logic                            ll_ready;
  logic [rf_wb_pkg::REG_IDX_W-1:0] ll_rd;
  logic [XLEN-1:0]                 ll_data;
  logic                            pipe_stall;
  logic [rf_wb_pkg::NUM_REGS-1:0]  pending_mask;
  logic                            reg_write;
  logic [rf_wb_pkg::REG_IDX_W-1:0] waddr;
  logic [XLEN-1:0]                 wdata;

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data, ll_valid, ll_rd, ll_data,
    input  ll_ready, pipe_stall, pending_mask, reg_write, waddr, wdata
  );

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data, ll_valid, ll_rd, ll_data,
    output ll_ready, pipe_stall, pending_mask, reg_write, waddr, wdata
  );

endinterface

`default_nettype wire

// File: rtl/wb_sync_fifo.sv
// ============================================================================
// Module   : wb_sync_fifo
// Purpose  : Power-of-two synchronous FIFO exposing per-slot contents and validity.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_sync_fifo
  import rf_wb_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = wb_req_t
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   push,
  input  wire T                       push_data,
  input  wire logic                   pop,
  output T                            head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0]            entry_valid,
  output T                            entries [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  // A slot is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(i) - rd_ptr;
    assign entry_valid[i] = ({1'b0, offset} < count);
    assign entries[i]     = mem[i];
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
// ============================================================================
// Module   : rf_writeback_arbiter
// Purpose  : Merges pipeline and long-latency results onto one RF write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int LL_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input wire logic              clk,
  input wire logic              reset,
  rf_writeback_arbiter_if.slave bus
);

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } req_t;

  localparam int CNT_W = $clog2(LL_DEPTH) + 1;
  localparam int SC_W  = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT - 1);
  localparam logic [SC_W-1:0]  SC_ONE     = SC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(LL_DEPTH);

  req_t                 fifo_head;
  req_t                 fifo_entries [LL_DEPTH];
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic [LL_DEPTH-1:0]  fifo_valid;

  logic                 pipe_win;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 head_loses;
  logic [SC_W-1:0]      starve_cnt;
  logic                 pipe_stall_q;
  logic                 reg_write_q;
  logic [REG_IDX_W-1:0] waddr_q;
  logic [XLEN-1:0]      wdata_q;
  logic [NUM_REGS-1:0]  pending;

  // rd==0 on either source is a no-op: the pipe does not compete, the LL side is swallowed.
  assign pipe_win   = bus.pipe_wb_valid && (bus.pipe_wb_rd != '0);
  assign fifo_pop   = !pipe_win && !fifo_empty;
  assign fifo_push  = bus.ll_valid && !fifo_full && (bus.ll_rd != '0);
  assign head_loses = !fifo_empty && !fifo_pop;

  wb_sync_fifo #(
    .DEPTH (LL_DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_data   ('{rd: bus.ll_rd, data: bus.ll_data}),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count),
    .entry_valid (fifo_valid),
    .entries     (fifo_entries)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      reg_write_q <= pipe_win || fifo_pop;
      if (pipe_win) begin
        waddr_q <= bus.pipe_wb_rd;
        wdata_q <= bus.pipe_wb_data;
      end else if (fifo_pop) begin
        waddr_q <= fifo_head.rd;
        wdata_q <= fifo_head.data;
      end
    end
  end

  // Counter saturates so a misbehaving upstream keeps re-triggering the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt   <= '0;
      pipe_stall_q <= 1'b0;
    end else begin
      pipe_stall_q <= head_loses && (starve_cnt == STARVE_MAX);
      if (!head_loses)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SC_ONE;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < LL_DEPTH; i++) begin
      if (fifo_valid[i]) pending[fifo_entries[i].rd] = 1'b1;
    end
  end

  assign bus.ll_ready     = !fifo_full;
  assign bus.pipe_stall   = pipe_stall_q;
  assign bus.pending_mask = pending;
  assign bus.reg_write    = reg_write_q;
  assign bus.waddr        = waddr_q;
  assign bus.wdata        = wdata_q;

  a_stall_honoured: assert property (@(posedge clk) disable iff (reset)
    pipe_stall_q |-> !bus.pipe_wb_valid);
  a_no_write_r0: assert property (@(posedge clk) disable iff (reset)
    reg_write_q |-> (waddr_q != '0));
  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    fifo_count <= CNT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
// ============================================================================
// Module   : tb_rf_writeback_arbiter
// Purpose  : Directed plus random checks of the RF writeback arbiter vs a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rf_writeback_arbiter;

  localparam int LL_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;
  localparam int XLEN         = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  // Reference model: queue of buffered results plus expected registered outputs.
  ent_t        q[$];
  logic        m_rw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_stall;
  int          m_losses;

  rf_writeback_arbiter_if #(.XLEN(XLEN)) ifc ();

  rf_writeback_arbiter #(
    .LL_DEPTH     (LL_DEPTH),
    .STARVE_LIMIT (STARVE_LIMIT),
    .XLEN         (XLEN)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_rw     = 1'b0;
    m_wa     = '0;
    m_wd     = '0;
    m_stall  = 1'b0;
    m_losses = 0;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_mask;
    exp_mask = '0;
    foreach (q[i]) exp_mask[q[i].rd] = 1'b1;
    chk("reg_write",    ifc.reg_write,    m_rw);
    chk("waddr",        ifc.waddr,        m_wa);
    chk("wdata",        ifc.wdata,        m_wd);
    chk("pipe_stall",   ifc.pipe_stall,   m_stall);
    chk("ll_ready",     ifc.ll_ready,     q.size() < LL_DEPTH);
    chk("pending_mask", ifc.pending_mask, exp_mask);
  endtask

  // One clock: drive inputs, compare current outputs, advance the model, cross the edge.
  task automatic step(input logic rs, input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic win;
    logic take;
    logic accept;
    logic lost;
    if (m_stall) pv = 1'b0;
    reset             = rs;
    ifc.pipe_wb_valid = pv;
    ifc.pipe_wb_rd    = prd;
    ifc.pipe_wb_data  = pd;
    ifc.ll_valid      = lv;
    ifc.ll_rd         = lrd;
    ifc.ll_data       = ld;
    check_outputs();
    if (rs) begin
      model_clear();
    end else begin
      win    = pv && (prd != 0);
      take   = !win && (q.size() != 0);
      accept = lv && (q.size() < LL_DEPTH) && (lrd != 0);
      lost   = (q.size() != 0) && !take;
      if (win) begin
        m_rw = 1'b1; m_wa = prd; m_wd = pd;
      end else if (take) begin
        m_rw = 1'b1; m_wa = q[0].rd; m_wd = q[0].data;
      end else begin
        m_rw = 1'b0;
      end
      m_stall = lost && (m_losses >= STARVE_LIMIT - 1);
      if (!lost) m_losses = 0;
      else if (m_losses < STARVE_LIMIT - 1) m_losses++;
      if (take) void'(q.pop_front());
      if (accept) q.push_back('{rd: lrd, data: ld});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    int k;
    int p;
    errors = 0;
    checks = 0;
    model_clear();
    reset             = 1'b1;
    ifc.pipe_wb_valid = 1'b0;
    ifc.pipe_wb_rd    = '0;
    ifc.pipe_wb_data  = '0;
    ifc.ll_valid      = 1'b0;
    ifc.ll_rd         = '0;
    ifc.ll_data       = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_reg_write", ifc.reg_write, 0);
    chk("rst_waddr",     ifc.waddr, 0);
    chk("rst_wdata",     ifc.wdata, 0);
    chk("rst_ll_ready",  ifc.ll_ready, 1);
    chk("rst_pending",   ifc.pending_mask, 0);
    chk("rst_stall",     ifc.pipe_stall, 0);
    idle();
    idle();

    // Pipe-only write, then hold, then rd 0 ignored
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    chk("pipe_we",   ifc.reg_write, 1);
    chk("pipe_addr", ifc.waddr, 5);
    chk("pipe_data", ifc.wdata, 32'hDEADBEEF);
    idle();
    chk("pipe_drop", ifc.reg_write, 0);
    chk("pipe_hold", ifc.wdata, 32'hDEADBEEF);
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h0);
    chk("pipe_r0", ifc.reg_write, 0);

    // Fill FIFO while pipe busy, then drain in order
    for (int i = 1; i <= 4; i++)
      step(1'b0, 1'b1, 5'd10, 32'hA0 + i, 1'b1, 5'(i), 32'h11 * i);
    chk("fill_mask",  ifc.pending_mask, 32'h1E);
    chk("fill_ready", ifc.ll_ready, 0);
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
    chk("drain1_addr", ifc.waddr, 1);
    chk("drain1_data", ifc.wdata, 32'h11);
    for (int i = 0; i < 4; i++) idle();
    chk("drain_mask", ifc.pending_mask, 0);

    // LL handshake to rd 0 is swallowed
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
    chk("ll_r0_mask", ifc.pending_mask, 0);

    // Collision: pipe beats FIFO head, head follows next cycle
    step(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h90);
    step(1'b0, 1'b1, 5'd7, 32'h70, 1'b0, 5'd0, 32'h0);
    chk("coll_first", ifc.waddr, 7);
    idle();
    chk("coll_second", ifc.waddr, 9);
    chk("coll_data",   ifc.wdata, 32'h90);
    idle();

    // Starvation guard
    step(1'b0, 1'b1, 5'd12, 32'hC0, 1'b1, 5'd3, 32'h33);
    k = 1;
    while (!ifc.pipe_stall && k <= 20) begin
      step(1'b0, 1'b1, 5'd12, 32'hC0 + k, 1'b0, 5'd0, 32'h0);
      k++;
    end
    chk("starve_lost", k - 1, STARVE_LIMIT);
    idle();
    chk("starve_we",    ifc.reg_write, 1);
    chk("starve_addr",  ifc.waddr, 3);
    chk("starve_clear", ifc.pipe_stall, 0);
    idle();

    // Reset mid-drain discards queued results
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 5'd20, 32'hB0, 1'b1, 5'(21 + i), 32'hE0 + i);
    step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("mid_rst_pending", ifc.pending_mask, 0);
    chk("mid_rst_ready",   ifc.ll_ready, 1);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("mid_rst_nowrite", ifc.reg_write, 0);
    end

    // Random traffic with varying pipe pressure
    for (int n = 0; n < 600; n++) begin
      logic [4:0] prd;
      logic [4:0] lrd;
      p   = (n < 200) ? 90 : (n < 400) ? 50 : 10;
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      step(1'b0, ($urandom_range(0, 99) < p), prd, $urandom,
           ($urandom_range(0, 99) < 60), lrd, $urandom);
    end
    for (int i = 0; i < 12; i++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side front end of the integer register file. Merges two result sources into the single reg_write/waddr/wdata write port.
- Source 1 is the in-order pipeline writeback stage: single-cycle, no backpressure, highest priority.
- Source 2 is the long-latency units (divider, load return), using a valid/ready handshake with an internal FIFO.
- Sits between the EX/MEM writeback logic and the register file. Also gives issue logic a per-register pending view for hazard checks.

Parameters:
- LL_DEPTH, 4, long-latency FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive cycles the FIFO head may lose arbitration before the pipeline is stalled.
- XLEN, 32, data width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pipe_wb_valid  in  1  pipeline result valid this cycle.
- pipe_wb_rd  in  5  pipeline destination register.
- pipe_wb_data  in  XLEN  pipeline result.
- ll_valid  in  1  long-latency result offered.
- ll_ready  out  1  FIFO can accept; equals !full.
- ll_rd  in  5  long-latency destination register.
- ll_data  in  XLEN  long-latency result.
- pipe_stall  out  1  request that upstream hold pipe_wb_valid low next cycle.
- pending_mask  out  32  bit r set while any FIFO entry targets register r.
- reg_write  out  1  register-file write enable.
- waddr  out  5  register-file write address.
- wdata  out  XLEN  register-file write data.

Behaviour:
- Synchronous reset, active-high, takes effect on the clk edge. Clears FIFO pointers and count, starvation counter, pipe_stall, reg_write, waddr and wdata. pending_mask=0 and ll_ready=1 on the first cycle after reset.
- Reset mid-operation discards all buffered results; none are written.
- Outputs reg_write, waddr and wdata are registered, one cycle after the winning input.
- A pipe write uses pipe_wb_rd/data. A FIFO write uses the head entry.
- rd==0 handling:
  - A pipe request with rd 0 is treated as idle. It does not win arbitration and no write is issued.
  - A long-latency handshake with ll_rd==0 is accepted (ll_ready honoured) but not enqueued.
- Arbitration each cycle:
  - Pipe valid with rd!=0 wins.
  - Otherwise a non-empty FIFO pops its head.
  - Otherwise reg_write=0 next cycle; waddr/wdata hold their previous values.
- FIFO push happens when ll_valid && ll_ready && ll_rd!=0.
- No bypass: an entry pushed in cycle N pops no earlier than N+1, so the earliest write is visible at N+2.
- Simultaneous push and pop when full is not allowed, because ll_ready is low when full. When not full, simultaneous push and pop leaves the count unchanged.
- Pointers wrap modulo LL_DEPTH. The count register is $clog2(LL_DEPTH)+1 bits.
- pending_mask is combinational: the OR of one-hot decode(rd) over valid FIFO entries. It clears in the cycle after the entry pops.
- Starvation guard:
  - starve_cnt increments each cycle the FIFO is non-empty and its head does not pop.
  - It clears on any pop or when the FIFO is empty.
  - When starve_cnt==STARVE_LIMIT-1 and the head loses again, pipe_stall is asserted, registered, for exactly one cycle.
  - Upstream must keep pipe_wb_valid=0 in that cycle, so the head pops then.
  - If upstream violates this, the pipe still wins, starve_cnt saturates, pipe_stall re-asserts the following cycle, and a simulation assertion fires.
- Write-after-write ordering between the pipe and FIFO for the same rd is the issue logic's responsibility, enforced via pending_mask. This block does not reorder or compare.
- Assertions:
  - no push when full, no pop when empty;
  - pipe_wb_valid must be low in a pipe_stall cycle;
  - reg_write must never be high with waddr==0.

Decomposition:
- Package rf_wb_pkg: XLEN default, REG_IDX_W=5, NUM_REGS=32, and a typedef wb_req_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
- One natural sub-module: wb_sync_fifo (parameterised depth/type, synchronous active-high reset). It exposes full, empty, count and an entry-valid vector so the parent can build pending_mask.
- Arbitration, starvation counter and output register stay in the top module.

Test Plan:
- Reset then idle: reset high 2 cycles, then idle.
  -> reg_write=0, waddr=0, wdata=0, ll_ready=1, pending_mask=0, pipe_stall=0.
- Pipe only: pipe_wb_valid=1, rd=5, data=0xDEADBEEF at cycle N.
  -> reg_write=1, waddr=5, wdata=0xDEADBEEF at N+1, then reg_write=0.
  - Same with rd=0 -> no write.
- Long-latency fill: push rd=1..4 with data 0x11..0x44 while the pipe is busy.
  -> ll_ready=0 after the 4th push; pending_mask=0x1E.
  - Then drop the pipe -> writes 1,2,3,4 in order on consecutive cycles; pending_mask returns to 0.
- Collision: cycle N has pipe rd=7, 0x70 and FIFO head rd=9, 0x90.
  -> write 7 at N+1, write 9 at N+2.
- Starvation: FIFO holds rd=3 with the pipe valid every cycle.
  -> pipe_stall high for one cycle after 8 lost cycles; with the pipe held low, rd=3 is written the next cycle and starve_cnt returns to 0.
- Reset mid-drain: 3 entries queued, reset asserted for 1 cycle.
  -> no further writes, pending_mask=0, ll_ready=1.
